// File: rtl/adbg_or1k_stall_cmd.sv
// rtl/adbg_or1k_stall_cmd.sv - JTAG-side command decoder for the OR1K stall register (TCK domain)
module adbg_or1k_stall_cmd #(
    parameter int NB_CORES = 4,
    parameter int CIDX_W   = (NB_CORES > 1) ? $clog2(NB_CORES) : 1
) (
    input  logic                tck_i,
    input  logic                trstn_i,
    input  logic                module_select_i,
    input  logic                capture_dr_i,
    input  logic                shift_dr_i,
    input  logic                update_dr_i,
    input  logic                tdi_i,
    input  logic [NB_CORES-1:0] ctrl_reg_i,
    output logic                tdo_o,
    output logic                we_o,
    output logic [NB_CORES-1:0] data_o,
    output logic                err_o
);

    localparam int CNT_W = $clog2(NB_CORES + 2);

    localparam logic [3:0] OP_NOP  = 4'h0;
    localparam logic [3:0] OP_WREG = 4'h9;
    localparam logic [3:0] OP_SETB = 4'hA;
    localparam logic [3:0] OP_CLRB = 4'hB;
    localparam logic [3:0] OP_RREG = 4'hD;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_OPCODE,
        ST_PAYLOAD,
        ST_READ,
        ST_DONE
    } state_t;

    state_t              state_q;
    logic [CNT_W-1:0]    cnt_q;
    logic [CNT_W-1:0]    cnt_d;
    logic [CNT_W-1:0]    plen_q;
    logic [3:0]          op_q;
    logic [3:0]          op_d;
    logic [NB_CORES-1:0] in_q;
    logic [NB_CORES-1:0] data_q;
    logic [NB_CORES:0]   out_q;
    logic                tdo_q;
    logic                we_q;
    logic                err_q;

    logic [CIDX_W-1:0]   idx;
    logic [NB_CORES-1:0] onehot;
    logic [NB_CORES-1:0] in_bit;
    logic                idx_ok;

    always_comb begin
        cnt_d  = cnt_q + 1'b1;
        op_d   = {tdi_i, op_q[3:1]};
        idx    = in_q[CIDX_W-1:0];
        onehot = NB_CORES'(1) << idx;
        in_bit = NB_CORES'(tdi_i) << cnt_q;
        // A non-power-of-two core count leaves index codes with no stall bit behind them
        idx_ok = (int'(idx) < NB_CORES);
    end

    always_ff @(posedge tck_i or negedge trstn_i) begin
        if (!trstn_i) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            plen_q  <= '0;
            op_q    <= '0;
            in_q    <= '0;
            out_q   <= '0;
            data_q  <= '0;
            tdo_q   <= 1'b0;
            we_q    <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            we_q <= 1'b0;
            if (capture_dr_i) begin
                if (module_select_i) begin
                    state_q <= ST_OPCODE;
                    cnt_q   <= '0;
                    op_q    <= '0;
                    in_q    <= '0;
                    out_q   <= '0;
                    tdo_q   <= 1'b0;
                end else begin
                    state_q <= ST_IDLE;
                end
            end else if (module_select_i && update_dr_i) begin
                case (state_q)
                    ST_OPCODE, ST_PAYLOAD: err_q <= 1'b1;
                    ST_READ:               err_q <= 1'b0;
                    ST_DONE: begin
                        case (op_q)
                            OP_WREG: begin
                                data_q <= in_q;
                                we_q   <= 1'b1;
                            end
                            OP_SETB: begin
                                if (idx_ok) begin
                                    data_q <= ctrl_reg_i | onehot;
                                    we_q   <= 1'b1;
                                end else begin
                                    err_q <= 1'b1;
                                end
                            end
                            OP_CLRB: begin
                                if (idx_ok) begin
                                    data_q <= ctrl_reg_i & ~onehot;
                                    we_q   <= 1'b1;
                                end else begin
                                    err_q <= 1'b1;
                                end
                            end
                            OP_RREG: err_q <= 1'b0;
                            default: ;
                        endcase
                    end
                    default: ;
                endcase
                state_q <= ST_IDLE;
                out_q   <= '0;
                tdo_q   <= 1'b0;
            end else if (module_select_i && shift_dr_i) begin
                case (state_q)
                    ST_OPCODE: begin
                        op_q  <= op_d;
                        cnt_q <= cnt_d;
                        if (cnt_q == CNT_W'(3)) begin
                            tdo_q <= err_q;
                            cnt_q <= '0;
                            case (op_d)
                                OP_NOP: state_q <= ST_DONE;
                                OP_WREG: begin
                                    state_q <= ST_PAYLOAD;
                                    plen_q  <= CNT_W'(NB_CORES);
                                end
                                OP_SETB, OP_CLRB: begin
                                    state_q <= ST_PAYLOAD;
                                    plen_q  <= CNT_W'(CIDX_W);
                                end
                                OP_RREG: begin
                                    state_q <= ST_READ;
                                    out_q   <= {ctrl_reg_i, err_q};
                                end
                                default: begin
                                    state_q <= ST_DONE;
                                    err_q   <= 1'b1;
                                end
                            endcase
                        end
                    end
                    ST_PAYLOAD: begin
                        in_q  <= in_q | in_bit;
                        cnt_q <= cnt_d;
                        if (cnt_d == plen_q) begin
                            state_q <= ST_DONE;
                        end
                    end
                    ST_READ: begin
                        // Error bit went out in the decode cycle; ctrl bits follow LSB first
                        out_q <= out_q >> 1;
                        tdo_q <= out_q[1];
                        cnt_q <= cnt_d;
                        if (cnt_d == CNT_W'(NB_CORES + 1)) begin
                            state_q <= ST_DONE;
                            tdo_q   <= 1'b0;
                        end
                    end
                    default: tdo_q <= 1'b0;
                endcase
            end
        end
    end

    assign tdo_o  = tdo_q;
    assign we_o   = we_q;
    assign data_o = data_q;
    assign err_o  = err_q;

endmodule

// File: tb/tb_adbg_or1k_stall_cmd.sv
// tb/tb_adbg_or1k_stall_cmd.sv - directed self-checking bench for adbg_or1k_stall_cmd
module tb_adbg_or1k_stall_cmd;

    logic       tck = 1'b0;
    logic       trstn = 1'b0;
    logic       sel4 = 1'b0;
    logic       sel3 = 1'b0;
    logic       cap = 1'b0;
    logic       sh = 1'b0;
    logic       upd = 1'b0;
    logic       tdi = 1'b0;
    logic [3:0] ctrl4 = '0;
    logic [2:0] ctrl3 = '0;
    logic       tdo4, we4, err4;
    logic [3:0] data4;
    logic       tdo3, we3, err3;
    logic [2:0] data3;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 tck = ~tck;

    adbg_or1k_stall_cmd #(.NB_CORES(4)) dut4 (
        .tck_i(tck), .trstn_i(trstn), .module_select_i(sel4),
        .capture_dr_i(cap), .shift_dr_i(sh), .update_dr_i(upd), .tdi_i(tdi),
        .ctrl_reg_i(ctrl4), .tdo_o(tdo4), .we_o(we4), .data_o(data4), .err_o(err4)
    );

    adbg_or1k_stall_cmd #(.NB_CORES(3)) dut3 (
        .tck_i(tck), .trstn_i(trstn), .module_select_i(sel3),
        .capture_dr_i(cap), .shift_dr_i(sh), .update_dr_i(upd), .tdi_i(tdi),
        .ctrl_reg_i(ctrl3), .tdo_o(tdo3), .we_o(we3), .data_o(data3), .err_o(err3)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step(input logic c, input logic s, input logic u, input logic t);
        cap = c; sh = s; upd = u; tdi = t;
        @(posedge tck);
        @(negedge tck);
        cap = 1'b0; sh = 1'b0; upd = 1'b0; tdi = 1'b0;
    endtask

    task automatic start_frame();
        step(1'b1, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic shift_bits(input logic [7:0] v, input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b1, 1'b0, v[i]);
    endtask

    task automatic do_update(output logic first4, output int w4, output int w3);
        step(1'b0, 1'b0, 1'b1, 1'b0);
        first4 = we4;
        w4 = int'(we4);
        w3 = int'(we3);
        repeat (3) begin
            step(1'b0, 1'b0, 1'b0, 1'b0);
            w4 += int'(we4);
            w3 += int'(we3);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        logic       first;
        int         w4, w3;
        logic [3:0] rexp;

        @(negedge tck);
        repeat (2) @(negedge tck);
        check_eq("rst_tdo4", tdo4, 0);
        check_eq("rst_we4", we4, 0);
        check_eq("rst_data4", data4, 0);
        check_eq("rst_err4", err4, 0);
        check_eq("rst_data3", data3, 0);
        trstn = 1'b1;
        sel4  = 1'b1;
        step(1'b0, 1'b0, 1'b0, 1'b0);

        // WREG 1010
        start_frame();
        shift_bits(8'h09, 4);
        shift_bits(8'b1010, 4);
        do_update(first, w4, w3);
        check_eq("wreg_we_n1", first, 1);
        check_eq("wreg_we_count", w4, 1);
        check_eq("wreg_data", data4, 4'b1010);
        check_eq("wreg_err", err4, 0);

        // SETB idx 2 onto 0001
        ctrl4 = 4'b0001;
        start_frame();
        shift_bits(8'h0A, 4);
        shift_bits(8'd2, 2);
        do_update(first, w4, w3);
        check_eq("setb_we_count", w4, 1);
        check_eq("setb_data", data4, 4'b0101);

        // CLRB idx 0 from 0101
        ctrl4 = 4'b0101;
        start_frame();
        shift_bits(8'h0B, 4);
        shift_bits(8'd0, 2);
        do_update(first, w4, w3);
        check_eq("clrb_we_count", w4, 1);
        check_eq("clrb_data", data4, 4'b0100);

        // illegal opcode 0x3
        start_frame();
        shift_bits(8'h03, 4);
        do_update(first, w4, w3);
        check_eq("badop_we_count", w4, 0);
        check_eq("badop_err", err4, 1);
        check_eq("badop_data", data4, 4'b0100);

        // RREG: err then ctrl 0110 LSB first
        ctrl4 = 4'b0110;
        rexp  = 4'b0110;
        start_frame();
        shift_bits(8'h0D, 4);
        check_eq("rreg_tdo_err", tdo4, 1);
        for (int i = 0; i < 4; i++) begin
            step(1'b0, 1'b1, 1'b0, 1'b0);
            check_eq($sformatf("rreg_tdo_b%0d", i), tdo4, rexp[i]);
        end
        step(1'b0, 1'b1, 1'b0, 1'b0);
        check_eq("rreg_tdo_done", tdo4, 0);
        do_update(first, w4, w3);
        check_eq("rreg_we_count", w4, 0);
        check_eq("rreg_err_clr", err4, 0);

        // truncated WREG (2 of 4 payload bits)
        start_frame();
        shift_bits(8'h09, 4);
        shift_bits(8'b11, 2);
        do_update(first, w4, w3);
        check_eq("trunc_we_count", w4, 0);
        check_eq("trunc_err", err4, 1);
        check_eq("trunc_data", data4, 4'b0100);

        // clear err with a read, then same truncated frame while deselected
        start_frame();
        shift_bits(8'h0D, 4);
        check_eq("rreg2_tdo_err", tdo4, 1);
        do_update(first, w4, w3);
        check_eq("rreg2_err_clr", err4, 0);
        sel4 = 1'b0;
        start_frame();
        shift_bits(8'h09, 4);
        shift_bits(8'b11, 2);
        do_update(first, w4, w3);
        check_eq("desel_we_count", w4, 0);
        check_eq("desel_err", err4, 0);
        check_eq("desel_data", data4, 4'b0100);

        // capture mid-frame restarts without error
        sel4 = 1'b1;
        start_frame();
        shift_bits(8'h09, 4);
        shift_bits(8'b01, 2);
        start_frame();
        shift_bits(8'h09, 4);
        shift_bits(8'b0011, 4);
        do_update(first, w4, w3);
        check_eq("restart_we_count", w4, 1);
        check_eq("restart_data", data4, 4'b0011);
        check_eq("restart_err", err4, 0);

        // NB_CORES=3: valid SETB idx 1, then out-of-range idx 3
        sel4  = 1'b0;
        sel3  = 1'b1;
        ctrl3 = 3'b000;
        start_frame();
        shift_bits(8'h0A, 4);
        shift_bits(8'd1, 2);
        do_update(first, w4, w3);
        check_eq("n3_setb1_we_count", w3, 1);
        check_eq("n3_setb1_data", data3, 3'b010);
        ctrl3 = 3'b010;
        start_frame();
        shift_bits(8'h0A, 4);
        shift_bits(8'd3, 2);
        do_update(first, w4, w3);
        check_eq("n3_setb3_we_count", w3, 0);
        check_eq("n3_setb3_err", err3, 1);
        check_eq("n3_setb3_data", data3, 3'b010);

        // reset while in PAYLOAD
        sel3 = 1'b0;
        sel4 = 1'b1;
        start_frame();
        shift_bits(8'h09, 4);
        shift_bits(8'b11, 2);
        trstn = 1'b0;
        #1;
        check_eq("arst_tdo4", tdo4, 0);
        check_eq("arst_we4", we4, 0);
        check_eq("arst_data4", data4, 0);
        check_eq("arst_err4", err4, 0);
        check_eq("arst_err3", err3, 0);
        check_eq("arst_data3", data3, 0);
        @(negedge tck);
        trstn = 1'b1;
        shift_bits(8'b11, 2);
        do_update(first, w4, w3);
        check_eq("arst_we_count", w4, 0);
        check_eq("arst_err_after", err4, 0);
        check_eq("arst_data_after", data4, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
